uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver for the serial I/O subsystem.
- Oversampled RxD input, gated by an external baud tick.
- Data width, oversample ratio, parity mode and stop-bit count are configurable; start bit is glitch-qualified.
- Delivers each frame through a valid/ready holding register with parity, framing, break and overrun status.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9, LSB received first
OVERSAMPLE, 16, sample_en pulses per bit period, even, legal 8..32

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-low reset
sample_en  input  1  one-cycle pulse per oversample tick
RxD  input  1  asynchronous serial line, idle high
parity_en  input  1  1 = frame carries a parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits expected
rx_data  output  DATA_WIDTH  received word, held while rx_valid
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts when rx_valid & rx_ready
rx_parity_err  output  1  parity mismatch, qualified by rx_valid
rx_frame_err  output  1  a stop bit sampled 0, qualified by rx_valid
rx_break  output  1  break frame, qualified by rx_valid
rx_overrun  output  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset (rst=0, async):
  - State IDLE, counters 0, sync flops set to 1.
  - rx_data=0; rx_valid, rx_parity_err, rx_frame_err, rx_break and rx_overrun all 0.
  - A frame in progress is aborted with no output.
- RxD passes through a 2-flop synchronizer. Start detection uses the synced line: a falling edge (previous 1, current 0), so a line held low out of reset never starts a frame.
- The config inputs (parity_en, parity_odd, two_stop) are latched at start detection; changes mid-frame are ignored.
- Bit timing:
  - On start detection, the tick counter clears to 0.
  - The counter increments on each sample_en and wraps at OVERSAMPLE-1; the wrap ends the bit.
  - M = OVERSAMPLE/2. The bit value is the majority of the samples at counts M-1, M and M+1, decided at count M+1.
- States:
  - IDLE: on falling edge -> START.
  - START: decided bit 1 -> IDLE (false start, nothing reported); decided bit 0 -> DATA at the bit wrap.
  - DATA: shift DATA_WIDTH bits in, LSB first. After the last bit -> PARITY if parity_en, else STOP1.
  - PARITY: capture the parity bit. -> STOP1.
  - STOP1: at the decision, if two_stop -> STOP2 at the bit wrap; otherwise the frame completes and the FSM -> IDLE immediately (mid-stop resync).
  - STOP2: at the decision the frame completes and the FSM -> IDLE.
- Status computed at frame completion:
  - Parity error: XOR(data) ^ parity_bit ^ parity_odd != 0. Forced 0 when parity_en=0.
  - Frame error: any stop bit decided 0.
  - Break: all data bits 0, parity bit 0 (if present) and STOP1 decided 0. Break implies frame error and is delivered with rx_data=0.
- Handshake and holding register:
  - On frame completion, if the holding register is empty, or rx_ready=1 in the same cycle: load rx_data and the status bits; rx_valid=1 on the next clock.
  - If rx_valid=1 and rx_ready=0: drop the new frame, pulse rx_overrun for 1 cycle, keep the old data.
  - rx_valid clears the cycle after acceptance unless a new frame loads in that same cycle.
- Latency: rx_valid rises 1 clk after the final stop-bit decision.
- sample_en=0: the FSM and counters hold. A frame stalls indefinitely; no timeout.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: 3-sample majority vote as above.
- Undefined: single sample at count M, decided at count M. All other timing is unchanged.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - the status struct {parity_err, frame_err, brk};
  - legal-range constants for DATA_WIDTH and OVERSAMPLE.
- Sub-module uart_rx_sampler holds the 2-flop synchronizer, edge detect and majority-vote logic.

Test Plan:
- 8N1, sample_en every clk, frame 0xA5 -> rx_data=0xA5, rx_valid rises 1 clk after the stop decision, all errors 0.
- DATA_WIDTH=7, even parity, frame 0x55 with parity bit 1 -> rx_data=0x55, rx_parity_err=1; repeat with parity_odd=1 -> rx_parity_err=0.
- RxD low pulse of 4 ticks, then high -> FSM returns to IDLE, no rx_valid. A single 1-tick glitch at count M inside data bit 3 of 0x00 -> rx_data=0x00 with majority enabled, 0x08 with majority disabled.
- All-zero line for a full 8E2 frame -> rx_data=0, rx_break=1, rx_frame_err=1.
- Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, one rx_overrun pulse. Completion coinciding with rx_ready=1 -> 0x22 loads, no overrun.
- rst low mid-DATA, then a clean 0x3C frame -> no output from the aborted frame; 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic brk;
  } rx_status_t;

  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;
  localparam int OS_MIN = 8;
  localparam int OS_MAX = 32;

  function automatic bit cfg_legal(input int dw, input int os);
    return (dw >= DW_MIN) && (dw <= DW_MAX) && (os >= OS_MIN) && (os <= OS_MAX) && (os % 2 == 0);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RxD synchronizer, falling-edge detect and bit decision.
// UART_RX_MAJORITY_EN selects a 3-sample vote around mid-bit; otherwise a single mid-bit sample.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic          rxd,
  input  logic [CW-1:0] cnt,
  output logic          fall,
  output logic          bit_val,
  output logic          decide
);

  localparam int M = OVERSAMPLE / 2;

  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Idle-high reset of prev means a line held low out of reset never starts a frame.
  assign fall = prev & ~sync2;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_A   = CW'(M - 1);
  localparam logic [CW-1:0] CNT_B   = CW'(M);
  localparam logic [CW-1:0] CNT_DEC = CW'(M + 1);

  logic samp_a, samp_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (sample_en) begin
      if (cnt == CNT_A) samp_a <= sync2;
      if (cnt == CNT_B) samp_b <= sync2;
    end
  end

  assign decide  = sample_en && (cnt == CNT_DEC);
  assign bit_val = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
`else
  localparam logic [CW-1:0] CNT_DEC = CW'(M);

  assign decide  = sample_en && (cnt == CNT_DEC);
  assign bit_val = sync2;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready holding register.
// Bit decision style is selected by the UART_RX_MAJORITY_EN macro (see uart_rx_sampler).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic                  RxD,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_break,
  output logic                  rx_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  generate
    if (!cfg_legal(DATA_WIDTH, OVERSAMPLE)) begin : g_bad_cfg
      $error("uart_rx_param: DATA_WIDTH or OVERSAMPLE out of legal range");
    end
  endgenerate

  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit, stop1_bit;
  logic                  cfg_pen, cfg_odd, cfg_two;
  rx_status_t            status_reg, frame_status;
  logic                  fall, bit_val, decide;
  logic                  frame_done, stop1_now;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .CW        (CW)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en),
    .rxd      (RxD),
    .cnt      (cnt),
    .fall     (fall),
    .bit_val  (bit_val),
    .decide   (decide)
  );

  // Single stop: the frame completes at the STOP1 decision, not at the bit end.
  assign frame_done = decide && (((state == STOP1) && !cfg_two) || (state == STOP2));
  assign stop1_now  = (state == STOP1) ? bit_val : stop1_bit;

  assign frame_status = '{
    parity_err: cfg_pen & (^shreg ^ par_bit ^ cfg_odd),
    frame_err:  ~stop1_now | ((state == STOP2) & ~bit_val),
    brk:        (shreg == '0) & ~(cfg_pen & par_bit) & ~stop1_now
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop1_bit  <= 1'b1;
      cfg_pen    <= 1'b0;
      cfg_odd    <= 1'b0;
      cfg_two    <= 1'b0;
      status_reg <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          status_reg <= frame_status;
          rx_valid   <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end

      if (state == IDLE) begin
        if (fall) begin
          state   <= START;
          cnt     <= '0;
          bit_idx <= '0;
          cfg_pen <= parity_en;
          cfg_odd <= parity_odd;
          cfg_two <= two_stop;
        end
      end else if (sample_en) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

        if (decide) begin
          case (state)
            START:   if (bit_val) state <= IDLE;
            DATA:    shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            PARITY:  par_bit <= bit_val;
            STOP1: begin
              stop1_bit <= bit_val;
              if (!cfg_two) state <= IDLE;
            end
            STOP2:   state <= IDLE;
            default: ;
          endcase
        end

        // Decisions never land on the wrap count, so these cannot collide with the above.
        if (cnt == CNT_LAST) begin
          case (state)
            START: state <= DATA;
            DATA: begin
              if (bit_idx == BIT_LAST) state <= cfg_pen ? PARITY : STOP1;
              else bit_idx <= bit_idx + 1'b1;
            end
            PARITY:  state <= STOP1;
            STOP1:   state <= STOP2;
            default: ;
          endcase
        end
      end
    end
  end

  assign rx_parity_err = status_reg.parity_err;
  assign rx_frame_err  = status_reg.frame_err;
  assign rx_break      = status_reg.brk;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed cases plus randomized frames against a frame-level model.
module tb_uart_rx_param;

  localparam int OS = 16;
  localparam int M  = OS / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = M + 1;
  localparam logic [8:0] GLITCH_DATA = 9'h000;
`else
  localparam int DEC = M;
  localparam logic [8:0] GLITCH_DATA = 9'h008;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_en = 1'b1;
  logic rxd_a = 1'b1, rxd_b = 1'b1;
  logic pen = 1'b0, podd = 1'b0, two = 1'b0;
  logic rx_ready = 1'b0;

  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_parity_err_a, rx_frame_err_a, rx_break_a, rx_overrun_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_b, rx_parity_err_b, rx_frame_err_b, rx_break_b, rx_overrun_b;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_a = 0, ovr_b = 0;
  logic [11:0] cap_a[$];
  logic [11:0] cap_b[$];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut_a (
    .clk(clk), .rst(rst), .sample_en(sample_en), .RxD(rxd_a),
    .parity_en(pen), .parity_odd(podd), .two_stop(two),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a),
    .rx_break(rx_break_a), .rx_overrun(rx_overrun_a)
  );

  uart_rx_param #(.DATA_WIDTH(7), .OVERSAMPLE(OS)) dut_b (
    .clk(clk), .rst(rst), .sample_en(sample_en), .RxD(rxd_b),
    .parity_en(pen), .parity_odd(podd), .two_stop(two),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b),
    .rx_break(rx_break_b), .rx_overrun(rx_overrun_b)
  );

  // Record every accepted word and every overrun pulse, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_a && rx_ready)
      cap_a.push_back({rx_break_a, rx_frame_err_a, rx_parity_err_a, 1'b0, rx_data_a});
    if (rx_valid_b && rx_ready)
      cap_b.push_back({rx_break_b, rx_frame_err_b, rx_parity_err_b, 2'b00, rx_data_b});
    if (rx_overrun_a) ovr_a++;
    if (rx_overrun_b) ovr_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: {brk, frame_err, parity_err, data[8:0]} from the bits put on the line.
  function automatic logic [11:0] model(input int dw, input logic [8:0] d, input logic p_en,
                                        input logic p_odd, input logic pb, input logic s1,
                                        input logic two_i, input logic s2);
    logic [8:0] m;
    logic perr, ferr, brk;
    m    = d & ((9'h1 << dw) - 9'h1);
    perr = p_en && ((^m) ^ pb ^ p_odd);
    ferr = !s1 || (two_i && !s2);
    brk  = (m == 9'h0) && (!p_en || !pb) && !s1;
    return {brk, ferr, perr, m};
  endfunction

  task automatic tick(input bit stall);
    @(posedge clk);
    #1;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        sample_en = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    sample_en = 1'b1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  // Drives one frame, OS ticks per bit. glitch flips the line for one tick at that tick index.
  task automatic send_frame(input int sel, input logic [8:0] data, input logic pb, input logic s1,
                            input logic s2, input int glitch, input bit probe,
                            input bit pulse_ready, input bit stall);
    logic [15:0] bits;
    int n, dw, dec;
    dw   = (sel == 0) ? 8 : 7;
    bits = '1;
    n    = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < dw; i++) begin bits[n] = data[i]; n++; end
    if (pen) begin bits[n] = pb; n++; end
    bits[n] = s1; n++;
    if (two) begin bits[n] = s2; n++; end
    // Final stop decision edge: 2-flop sync + edge detect, then DEC ticks into the last bit.
    dec = 4 + (n - 1) * OS + DEC;
    for (int j = 0; j < n * OS; j++) begin
      set_line(sel, bits[j / OS] ^ (j == glitch));
      if (j + 1 == dec) begin
        if (probe) check("latency_before", 32'(rx_valid_a), 32'd0);
        if (pulse_ready) rx_ready = 1'b1;
      end
      tick(stall);
      if (j + 1 == dec) begin
        if (probe) check("latency_after", 32'(rx_valid_a), 32'd1);
        if (pulse_ready) rx_ready = 1'b0;
      end
    end
    set_line(sel, 1'b1);
    repeat (2 * OS) tick(stall);
  endtask

  task automatic expect_frame(input int sel, input string tag, input logic [11:0] exp);
    int waited;
    logic [11:0] got;
    waited = 0;
    while (((sel == 0) ? cap_a.size() : cap_b.size()) == 0 && waited < 200) begin
      tick(1'b0);
      waited++;
    end
    if (((sel == 0) ? cap_a.size() : cap_b.size()) == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      got = (sel == 0) ? cap_a.pop_front() : cap_b.pop_front();
      $display("rx[%0d] %s: got %03h expected %03h", sel, tag, got, exp);
      check(tag, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovr_base;
    logic [8:0] d;
    logic pb, s1, s2, st;

    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {rx_data_a, rx_valid_a, rx_parity_err_a, rx_frame_err_a, rx_break_a, rx_overrun_a}, 32'd0);
    check("reset_b", {rx_data_b, rx_valid_b, rx_parity_err_b, rx_frame_err_b, rx_break_b, rx_overrun_b}, 32'd0);
    rst = 1'b1;
    repeat (4) tick(1'b0);

    // 8N1 0xA5 with latency probe, held until accepted.
    rx_ready = 1'b0;
    send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0);
    check("a5_data", 32'(rx_data_a), 32'h0A5);
    check("a5_status", {rx_parity_err_a, rx_frame_err_a, rx_break_a}, 32'd0);
    rx_ready = 1'b1;
    tick(1'b0);
    check("a5_release", 32'(rx_valid_a), 32'd0);
    cap_a.delete();

    // 7-bit even then odd parity, parity bit 1.
    pen = 1'b1; podd = 1'b0; two = 1'b0;
    send_frame(1, 9'h055, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    expect_frame(1, "par_even", model(7, 9'h055, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    podd = 1'b1;
    send_frame(1, 9'h055, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    expect_frame(1, "par_odd", model(7, 9'h055, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
    pen = 1'b0; podd = 1'b0;

    // Short low pulse is a false start.
    rxd_a = 1'b0;
    repeat (4) tick(1'b0);
    rxd_a = 1'b1;
    repeat (3 * OS) tick(1'b0);
    check("false_start_cap", cap_a.size(), 32'd0);
    check("false_start_valid", 32'(rx_valid_a), 32'd0);

    // One-tick glitch at mid-bit of data bit 3 of 0x00.
    send_frame(0, 9'h000, 1'b0, 1'b1, 1'b1, 1 + 4 * OS + M, 1'b0, 1'b0, 1'b0);
    expect_frame(0, "glitch", {3'b000, GLITCH_DATA});

    // Break: all-zero 8E2 frame.
    pen = 1'b1; podd = 1'b0; two = 1'b1;
    send_frame(0, 9'h000, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    expect_frame(0, "break", model(8, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    pen = 1'b0; two = 1'b0;

    // Overrun with the consumer stalled, then completion coinciding with rx_ready.
    rx_ready = 1'b0;
    ovr_base = ovr_a;
    send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    check("ovr_keep_data", 32'(rx_data_a), 32'h011);
    check("ovr_pulses", ovr_a - ovr_base, 32'd1);
    check("ovr_valid", 32'(rx_valid_a), 32'd1);
    send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    check("coincide_data", 32'(rx_data_a), 32'h022);
    check("coincide_no_ovr", ovr_a - ovr_base, 32'd1);
    expect_frame(0, "coincide_old", model(8, 9'h011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    rx_ready = 1'b1;
    expect_frame(0, "coincide_new", model(8, 9'h022, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));

    // Reset in the middle of a frame, then a clean frame.
    rxd_a = 1'b0;
    repeat (40) tick(1'b0);
    rst = 1'b0;
    rxd_a = 1'b1;
    repeat (3) tick(1'b0);
    check("midrst_outputs", {rx_data_a, rx_valid_a, rx_parity_err_a, rx_frame_err_a, rx_break_a}, 32'd0);
    rst = 1'b1;
    repeat (2 * OS) tick(1'b0);
    check("midrst_no_output", cap_a.size(), 32'd0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    expect_frame(0, "after_rst", model(8, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));

    // Randomized frames, with random config, stop errors and sample_en gaps.
    for (int f = 0; f < 40; f++) begin
      d    = 9'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      pb   = 1'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 3) != 0);
      s2   = ($urandom_range(0, 3) != 0);
      st   = 1'($urandom_range(0, 1));
      send_frame(0, d, pb, s1, s2, -1, 1'b0, 1'b0, st);
      expect_frame(0, "rand", model(8, d, pen, podd, pb, s1, two, s2));
    end
    check("rand_no_overrun", ovr_a - ovr_base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
